// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine controller.
package vm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vm_state_e;

    localparam logic [1:0] ITEM_NONE = 2'd0;
    localparam logic [1:0] ITEM1_ID  = 2'd1;
    localparam logic [1:0] ITEM2_ID  = 2'd2;
    localparam logic [1:0] ITEM3_ID  = 2'd3;

    localparam int COIN_P1_VALUE = 1;
    localparam int COIN_P5_VALUE = 5;

    // Even parity over a state code, available for downstream state checkers.
    function automatic logic state_parity(input vm_state_e st);
        return ^st;
    endfunction

endpackage

// File: rtl/vm_stock_counter.sv
// Per-item stock counter: loads STOCK_INIT at reset or restock,
// decrements on a vend and holds at zero until reloaded.
module vm_stock_counter #(
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 5
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               load,
    input  logic               dec,
    output logic               empty,
    output logic [STOCK_W-1:0] count
);

    localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(STOCK_INIT);

    logic [STOCK_W-1:0] count_q;

    // Stock register: reload has priority, zero is sticky against dec.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            count_q <= INIT_VAL;
        end else if (load) begin
            count_q <= INIT_VAL;
        end else if (dec && (count_q != {STOCK_W{1'b0}})) begin
            count_q <= count_q - {{(STOCK_W-1){1'b0}}, 1'b1};
        end else begin
            count_q <= count_q;
        end
    end

    assign count = count_q;
    assign empty = (count_q == {STOCK_W{1'b0}});

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: accumulates coin credit, vends one item per accepted
// select, then pays back remaining credit one unit per cycle.
module vend_controller
    import vm_pkg::*;
#(
    parameter int PRICE1     = 3,
    parameter int PRICE2     = 5,
    parameter int PRICE3     = 6,
    parameter int CREDIT_W   = 4,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 5
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                p1,
    input  logic                p5,
    input  logic                item1,
    input  logic                item2,
    input  logic                item3,
    input  logic                cancel,
    input  logic                restock,
    output logic                dispense,
    output logic [1:0]          dispense_id,
    output logic                change,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic [2:0]          sold_out
);

    localparam logic [CREDIT_W:0]   MAX_CREDIT_X = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   COIN1_X      = (CREDIT_W+1)'(COIN_P1_VALUE);
    localparam logic [CREDIT_W:0]   COIN5_X      = (CREDIT_W+1)'(COIN_P5_VALUE);
    localparam logic [CREDIT_W-1:0] PRICE1_X     = CREDIT_W'(PRICE1);
    localparam logic [CREDIT_W-1:0] PRICE2_X     = CREDIT_W'(PRICE2);
    localparam logic [CREDIT_W-1:0] PRICE3_X     = CREDIT_W'(PRICE3);
    localparam logic [CREDIT_W-1:0] ONE_X        = {{(CREDIT_W-1){1'b0}}, 1'b1};

    vm_state_e           state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [1:0]          vend_id_q, vend_id_d;

    logic [CREDIT_W:0]   coin_val_s;
    logic [CREDIT_W:0]   coin_sum_s;
    logic                coin_over_s;
    logic [CREDIT_W-1:0] credit_fit_s;
    logic [CREDIT_W-1:0] credit_vend_s;
    logic [1:0]          sel_id_s;
    logic [2:0]          sel_onehot_s;
    logic [CREDIT_W-1:0] sel_price_s;
    logic                sel_accept_s;
    logic                coin_reject_s;
    logic                load_s;
    logic [2:0]          dec_s;
    logic [2:0]          empty_s;
    logic [2:0]          in_stock_s;
    logic [STOCK_W-1:0]  stock1_s, stock2_s, stock3_s;

    // Coin arithmetic one bit wider than credit so overflow is visible.
    assign coin_val_s    = (p1 ? COIN1_X : {(CREDIT_W+1){1'b0}})
                         + (p5 ? COIN5_X : {(CREDIT_W+1){1'b0}});
    assign coin_sum_s    = {1'b0, credit_q} + coin_val_s;
    assign coin_over_s   = (coin_sum_s > MAX_CREDIT_X);
    assign credit_fit_s  = coin_over_s ? credit_q : coin_sum_s[CREDIT_W-1:0];
    assign credit_vend_s = credit_fit_s - sel_price_s;

    assign in_stock_s = {(stock3_s != {STOCK_W{1'b0}}),
                         (stock2_s != {STOCK_W{1'b0}}),
                         (stock1_s != {STOCK_W{1'b0}})};

    // Fixed-priority select; only the winner is checked against credit and stock.
    always_comb begin
        sel_id_s     = ITEM_NONE;
        sel_onehot_s = 3'b000;
        sel_price_s  = {CREDIT_W{1'b0}};
        if (item1) begin
            sel_id_s     = ITEM1_ID;
            sel_onehot_s = 3'b001;
            sel_price_s  = PRICE1_X;
        end else if (item2) begin
            sel_id_s     = ITEM2_ID;
            sel_onehot_s = 3'b010;
            sel_price_s  = PRICE2_X;
        end else if (item3) begin
            sel_id_s     = ITEM3_ID;
            sel_onehot_s = 3'b100;
            sel_price_s  = PRICE3_X;
        end else begin
            sel_id_s     = ITEM_NONE;
        end
        sel_accept_s = (sel_onehot_s != 3'b000)
                    && (credit_q >= sel_price_s)
                    && ((sel_onehot_s & in_stock_s) != 3'b000);
    end

    // Next-state, credit update, stock control and coin refusal.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_id_d     = vend_id_q;
        coin_reject_s = 1'b0;
        load_s        = 1'b0;
        dec_s         = 3'b000;
        case (state_q)
            IDLE, COLLECT: begin
                coin_reject_s = (p1 | p5) & coin_over_s;
                credit_d      = credit_fit_s;
                if (cancel && (state_q == COLLECT)) begin
                    state_d = CHANGE;
                end else if (restock) begin
                    load_s  = 1'b1;
                    state_d = (credit_fit_s == {CREDIT_W{1'b0}}) ? IDLE : COLLECT;
                end else if (sel_accept_s) begin
                    credit_d  = credit_vend_s;
                    dec_s     = sel_onehot_s;
                    vend_id_d = sel_id_s;
                    state_d   = DISPENSE;
                end else begin
                    state_d = (credit_fit_s == {CREDIT_W{1'b0}}) ? IDLE : COLLECT;
                end
            end
            DISPENSE: begin
                coin_reject_s = p1 | p5;
                state_d       = (credit_q != {CREDIT_W{1'b0}}) ? CHANGE : IDLE;
            end
            CHANGE: begin
                coin_reject_s = p1 | p5;
                if (credit_q <= ONE_X) begin
                    credit_d = {CREDIT_W{1'b0}};
                    state_d  = IDLE;
                end else begin
                    credit_d = credit_q - ONE_X;
                    state_d  = CHANGE;
                end
            end
            default: begin
                credit_d = {CREDIT_W{1'b0}};
                state_d  = IDLE;
            end
        endcase
    end

    // Controller state, credit and latched vend id.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= IDLE;
            credit_q  <= {CREDIT_W{1'b0}};
            vend_id_q <= ITEM_NONE;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            vend_id_q <= vend_id_d;
        end
    end

    vm_stock_counter #(.STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)) u_stock1 (
        .clk(clk), .nRst(nRst), .load(load_s), .dec(dec_s[0]),
        .empty(empty_s[0]), .count(stock1_s)
    );
    vm_stock_counter #(.STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)) u_stock2 (
        .clk(clk), .nRst(nRst), .load(load_s), .dec(dec_s[1]),
        .empty(empty_s[1]), .count(stock2_s)
    );
    vm_stock_counter #(.STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)) u_stock3 (
        .clk(clk), .nRst(nRst), .load(load_s), .dec(dec_s[2]),
        .empty(empty_s[2]), .count(stock3_s)
    );

    assign dispense    = (state_q == DISPENSE);
    assign dispense_id = (state_q == DISPENSE) ? vend_id_q : ITEM_NONE;
    assign change      = (state_q == CHANGE);
    assign busy        = (state_q == DISPENSE) || (state_q == CHANGE);
    assign credit      = credit_q;
    assign coin_reject = coin_reject_s;
    assign sold_out    = empty_s;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: cycle table plus hand-written
// overflow/refund and asynchronous-reset sequences.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       p1 = 1'b0, p5 = 1'b0;
    logic       item1 = 1'b0, item2 = 1'b0, item3 = 1'b0;
    logic       cancel = 1'b0, restock = 1'b0;
    logic       dispense, change, coin_reject, busy;
    logic [1:0] dispense_id;
    logic [3:0] credit;
    logic [2:0] sold_out;

    int checks = 0;
    int failures = 0;

    vend_controller dut (
        .clk(clk), .nRst(nRst), .p1(p1), .p5(p5),
        .item1(item1), .item2(item2), .item3(item3),
        .cancel(cancel), .restock(restock),
        .dispense(dispense), .dispense_id(dispense_id), .change(change),
        .coin_reject(coin_reject), .busy(busy), .credit(credit), .sold_out(sold_out)
    );

    always #5 clk = ~clk;

    // Input encoding {p1,p5,item1,item2,item3,cancel,restock}
    localparam logic [6:0] N  = 7'b0000000;
    localparam logic [6:0] P1 = 7'b1000000;
    localparam logic [6:0] P5 = 7'b0100000;
    localparam logic [6:0] I1 = 7'b0010000;
    localparam logic [6:0] I2 = 7'b0001000;
    localparam logic [6:0] I3 = 7'b0000100;
    localparam logic [6:0] CN = 7'b0000010;
    localparam logic [6:0] RS = 7'b0000001;

    typedef struct {
        logic [6:0] in;
        logic [3:0] credit;
        logic       disp;
        logic [1:0] id;
        logic       chg;
        logic       rej;
        logic       busy;
        logic [2:0] sold;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [6:0] in, input int cr, input logic disp,
                                input int id, input logic chg, input logic rej,
                                input logic bsy, input logic [2:0] sold);
        vec_t v;
        v.in = in; v.credit = 4'(cr); v.disp = disp; v.id = 2'(id);
        v.chg = chg; v.rej = rej; v.busy = bsy; v.sold = sold;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic [6:0] v);
        {p1, p5, item1, item2, item3, cancel, restock} = v;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and sample after settling.
    task automatic step(input logic [6:0] v);
        @(negedge clk);
        drive(v);
        #1;
    endtask

    function automatic logic [12:0] pack_obs();
        return {credit, dispense, dispense_id, change, coin_reject, busy, sold_out};
    endfunction

    initial begin
        int pulses;
        int busy_bad;
        logic done;

        // Test 1: p5 then item2, no change
        add(N, 0, 0, 0, 0, 0, 0, 3'b000);
        add(P5, 0, 0, 0, 0, 0, 0, 3'b000);
        add(I2, 5, 0, 0, 0, 0, 0, 3'b000);
        add(N, 0, 1, 2, 0, 0, 1, 3'b000);
        add(N, 0, 0, 0, 0, 0, 0, 3'b000);
        // Test 2: p1+p5 then item1, 3 change pulses; coin refused in DISPENSE
        add(P1 | P5, 0, 0, 0, 0, 0, 0, 3'b000);
        add(I1, 6, 0, 0, 0, 0, 0, 3'b000);
        add(P5, 3, 1, 1, 0, 1, 1, 3'b000);
        add(N, 3, 0, 0, 1, 0, 1, 3'b000);
        add(N, 2, 0, 0, 1, 0, 1, 3'b000);
        add(N, 1, 0, 0, 1, 0, 1, 3'b000);
        add(N, 0, 0, 0, 0, 0, 0, 3'b000);
        // Test 3: five vends of item3 empty it
        for (int k = 1; k <= 5; k++) begin
            add(P1 | P5, 0, 0, 0, 0, 0, 0, 3'b000);
            add(I3, 6, 0, 0, 0, 0, 0, 3'b000);
            add(N, 0, 1, 3, 0, 0, 1, (k == 5) ? 3'b100 : 3'b000);
        end
        add(P1 | P5, 0, 0, 0, 0, 0, 0, 3'b100);
        add(I3, 6, 0, 0, 0, 0, 0, 3'b100);
        add(N, 6, 0, 0, 0, 0, 0, 3'b100);
        add(RS, 6, 0, 0, 0, 0, 0, 3'b100);
        add(N, 6, 0, 0, 0, 0, 0, 3'b000);
        add(CN, 6, 0, 0, 0, 0, 0, 3'b000);
        for (int c = 6; c >= 1; c--) begin
            if (c == 4) add(P1, c, 0, 0, 1, 1, 1, 3'b000);
            else        add(N, c, 0, 0, 1, 0, 1, 3'b000);
        end
        add(N, 0, 0, 0, 0, 0, 0, 3'b000);
        // Test 5: restock blocks select, priority item1 over item3, price miss, cancel beats select
        add(P5, 0, 0, 0, 0, 0, 0, 3'b000);
        add(RS | I2, 5, 0, 0, 0, 0, 0, 3'b000);
        add(I1 | I3, 5, 0, 0, 0, 0, 0, 3'b000);
        add(N, 2, 1, 1, 0, 0, 1, 3'b000);
        add(N, 2, 0, 0, 1, 0, 1, 3'b000);
        add(N, 1, 0, 0, 1, 0, 1, 3'b000);
        add(N, 0, 0, 0, 0, 0, 0, 3'b000);
        add(P5, 0, 0, 0, 0, 0, 0, 3'b000);
        add(I3, 5, 0, 0, 0, 0, 0, 3'b000);
        add(CN | I2, 5, 0, 0, 0, 0, 0, 3'b000);
        for (int c = 5; c >= 1; c--) add(N, c, 0, 0, 1, 0, 1, 3'b000);
        add(N, 0, 0, 0, 0, 0, 0, 3'b000);
        // Double-coin overflow refused, exact fill to 15 accepted, vend from 15
        add(P5, 0, 0, 0, 0, 0, 0, 3'b000);
        add(P5, 5, 0, 0, 0, 0, 0, 3'b000);
        add(P1 | P5, 10, 0, 0, 0, 1, 0, 3'b000);
        add(P5, 10, 0, 0, 0, 0, 0, 3'b000);
        add(N, 15, 0, 0, 0, 0, 0, 3'b000);
        add(I3, 15, 0, 0, 0, 0, 0, 3'b000);
        add(N, 9, 1, 3, 0, 0, 1, 3'b000);
        for (int c = 9; c >= 1; c--) add(N, c, 0, 0, 1, 0, 1, 3'b000);
        add(N, 0, 0, 0, 0, 0, 0, 3'b000);

        // Reset held, then released away from a rising edge
        #2;
        check("reset_credit", 32'(credit), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;
        check("reset_stock2", 32'(dut.u_stock2.count), 32'd5);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].in);
            check($sformatf("row%0d", i), 32'(pack_obs()),
                  32'({vecs[i].credit, vecs[i].disp, vecs[i].id, vecs[i].chg,
                       vecs[i].rej, vecs[i].busy, vecs[i].sold}));
            if (i == 4) check("stock2_after_t1", 32'(dut.u_stock2.count), 32'd4);
        end

        // Test 4: fill to 15, p1 refused, cancel refunds 15 with busy held
        step(P5);
        step(P5);
        step(P5);
        step(P1);
        check("t4_reject", 32'(coin_reject), 32'd1);
        check("t4_credit15", 32'(credit), 32'd15);
        step(N);
        check("t4_credit_kept", 32'(credit), 32'd15);
        step(CN);
        pulses = 0;
        busy_bad = 0;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            step(N);
            if (change) pulses++;
            if (change !== busy) busy_bad++;
            if (!change && pulses > 0) done = 1'b1;
        end
        check("t4_done", 32'(done), 32'd1);
        check("t4_pulses", 32'(pulses), 32'd15);
        check("t4_busy", 32'(busy_bad), 32'd0);
        check("t4_idle_credit", 32'(credit), 32'd0);
        check("stock1_before_rst", 32'(dut.u_stock1.count), 32'd4);

        // Test 6: asynchronous reset in the middle of a refund
        step(P5);
        step(P5);
        step(P5);
        step(CN);
        step(N);
        step(N);
        step(N);
        check("t6_in_change", 32'({change, busy, credit}), 32'({1'b1, 1'b1, 4'd13}));
        #2;
        nRst = 1'b0;
        #1;
        check("t6_rst_outputs",
              32'({dispense, dispense_id, change, coin_reject, busy, credit, sold_out}), 32'd0);
        check("t6_rst_state", 32'(2'(dut.state_q)), 32'd0);
        check("t6_rst_stock1", 32'(dut.u_stock1.count), 32'd5);
        @(negedge clk);
        nRst = 1'b1;
        step(P5);
        step(I2);
        step(N);
        check("t6_vend_after", 32'({dispense, dispense_id, credit}), 32'({1'b1, 2'd2, 4'd0}));

        drive(N);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
